// File: rtl/mac_operand_sequencer_if.sv
// Handshake and operand bus between a MAC operand source and the sequencer.
// Ports: control (start/abort/vec_len/prec_level), beat input with
// in_valid/in_ready, registered operands, MAC controls and status.
interface mac_operand_sequencer_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] vec_len;
   logic [1:0]       prec_level;
   logic [7:0]       act_in;
   logic [7:0]       wgt_in;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       act_out;
   logic [7:0]       wgt_out;
   logic [1:0]       prec_out;
   logic             mac_en;
   logic             acc_clr;
   logic             busy;
   logic             done;
   logic             err;
   logic [LEN_W-1:0] beat_cnt;

   modport master (
      output start, abort, vec_len, prec_level,
      output act_in, wgt_in, in_valid,
      input  in_ready, act_out, wgt_out, prec_out,
      input  mac_en, acc_clr, busy, done, err, beat_cnt
   );

   modport slave (
      input  start, abort, vec_len, prec_level,
      input  act_in, wgt_in, in_valid,
      output in_ready, act_out, wgt_out, prec_out,
      output mac_en, acc_clr, busy, done, err, beat_cnt
   );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds vec_len operand beats to a MAC, then waits out its pipeline.
// Ports: clk, rstn (async active-low), bus (slave side of the interface).
module mac_operand_sequencer #(
   parameter int DRAIN_CYCLES = 2,
   parameter int LEN_W        = 8
) (
   input logic                    clk,
   input logic                    rstn,
   mac_operand_sequencer_if.slave bus
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [1:0]       prec_q, prec_d;
   logic [7:0]       act_q, act_d;
   logic [7:0]       wgt_q, wgt_d;
   logic [DW-1:0]    drn_q, drn_d;
   logic             mac_en_q, mac_en_d;
   logic             first_q, first_d;
   logic             err_q, err_d;
   logic             rdy;
   logic             xfer;

   // RUN never sees cnt==len except for a zero-length vector.
   assign rdy  = (state_q == RUN) && (cnt_q != len_q);
   assign xfer = rdy && bus.in_valid && !bus.abort;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      prec_d   = prec_q;
      act_d    = act_q;
      wgt_d    = wgt_q;
      drn_d    = drn_q;
      mac_en_d = xfer;
      first_d  = 1'b0;
      err_d    = 1'b0;

      if (xfer) begin
         act_d = bus.act_in;
         wgt_d = bus.wgt_in;
         cnt_d = cnt_q + LEN_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d  = bus.vec_len;
               prec_d = bus.prec_level;
               cnt_d  = '0;
               if (bus.prec_level == 2'b11) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  first_d = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (len_q == '0) begin
               state_d = DONE;
            end else if (xfer && (cnt_q + LEN_W'(1) == len_q)) begin
               drn_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // First DRAIN cycle coincides with the final mac_en.
            if (drn_q == DW'(DRAIN_CYCLES - 1)) begin
               state_d = DONE;
            end else begin
               drn_d = drn_q + DW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (bus.abort) begin
         state_d = IDLE;
         len_d   = len_q;
         prec_d  = prec_q;
         cnt_d   = cnt_q;
         first_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         prec_q   <= '0;
         act_q    <= '0;
         wgt_q    <= '0;
         drn_q    <= '0;
         mac_en_q <= 1'b0;
         first_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         prec_q   <= prec_d;
         act_q    <= act_d;
         wgt_q    <= wgt_d;
         drn_q    <= drn_d;
         mac_en_q <= mac_en_d;
         first_q  <= first_d;
         err_q    <= err_d;
      end
   end

   assign bus.in_ready = rdy;
   assign bus.act_out  = act_q;
   assign bus.wgt_out  = wgt_q;
   assign bus.prec_out = prec_q;
   assign bus.mac_en   = mac_en_q;
   assign bus.acc_clr  = first_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.err      = err_q;
   assign bus.beat_cnt = cnt_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer with a cycle-schedule model.
// Ports: none; drives the interface and checks every cycle.
module tb_mac_operand_sequencer;
   localparam int LW = 8;
   localparam int D  = 2;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   mac_operand_sequencer_if #(.LEN_W(LW)) bus ();

   mac_operand_sequencer #(
      .DRAIN_CYCLES(D),
      .LEN_W       (LW)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] m_act = '0;
   logic [7:0] m_wgt = '0;
   logic [1:0] m_prec = '0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".busy"}, 32'(bus.busy), 0);
      check({tag, ".rdy"}, 32'(bus.in_ready), 0);
      check({tag, ".mac_en"}, 32'(bus.mac_en), 0);
      check({tag, ".done"}, 32'(bus.done), 0);
      check({tag, ".err"}, 32'(bus.err), 0);
      check({tag, ".clr"}, 32'(bus.acc_clr), 0);
   endtask

   task automatic check_zero(input string tag);
      check_idle(tag);
      check({tag, ".act"}, 32'(bus.act_out), 0);
      check({tag, ".wgt"}, 32'(bus.wgt_out), 0);
      check({tag, ".prec"}, 32'(bus.prec_out), 0);
      check({tag, ".cnt"}, 32'(bus.beat_cnt), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_idle("idle");
         bus.start    = 1'b0;
         bus.in_valid = 1'($urandom);
      end
   endtask

   // vmode: 0 random valid, 1 always valid, 2 valid except cycle 2
   task automatic run_op(input int len, input int prec, input int vmode,
                         input bit hold);
      int         sent;
      int         done_k;
      int         k;
      bit         xp;
      bit         rdy;
      bit         v;
      logic [7:0] a, w;
      sent = 0;
      xp   = 1'b0;
      @(negedge clk);
      check_idle("op0");
      check("op0.prec", 32'(bus.prec_out), 32'(m_prec));
      check("op0.act", 32'(bus.act_out), 32'(m_act));
      bus.start      = 1'b1;
      bus.vec_len    = LW'(len);
      bus.prec_level = 2'(prec);
      bus.in_valid   = 1'($urandom);
      m_prec = 2'(prec);
      if (prec == 3) done_k = 1;
      else if (len == 0) done_k = 2;
      else done_k = 1000;
      for (k = 1; k <= 300; k++) begin
         @(negedge clk);
         rdy = (prec != 3) && (sent < len);
         check("mac_en", 32'(bus.mac_en), 32'(xp));
         check("acc_clr", 32'(bus.acc_clr), 32'(k == 1 && prec != 3));
         check("in_ready", 32'(bus.in_ready), 32'(rdy));
         check("done", 32'(bus.done), 32'(k == done_k));
         check("err", 32'(bus.err), 32'(prec == 3 && k == done_k));
         check("busy", 32'(bus.busy), 1);
         check("beat_cnt", 32'(bus.beat_cnt), 32'(sent));
         check("act_out", 32'(bus.act_out), 32'(m_act));
         check("wgt_out", 32'(bus.wgt_out), 32'(m_wgt));
         check("prec_out", 32'(bus.prec_out), 32'(prec));
         bus.vec_len    = LW'($urandom);
         bus.prec_level = 2'($urandom);
         if (k == done_k) begin
            bus.start    = hold;
            bus.in_valid = 1'($urandom);
            break;
         end
         bus.start = 1'($urandom);
         if (vmode == 1) v = 1'b1;
         else if (vmode == 2) v = (k != 2);
         else v = 1'($urandom);
         a = 8'($urandom);
         w = 8'($urandom);
         bus.in_valid = v;
         bus.act_in   = a;
         bus.wgt_in   = w;
         xp = v && rdy;
         if (xp) begin
            m_act = a;
            m_wgt = w;
            sent++;
            if (sent == len) done_k = k + 1 + D;
         end
      end
      if (k > 300) check("timeout", 32'(k), 32'(done_k));
   endtask

   task automatic abort_then_reset();
      @(negedge clk);
      check_idle("ab0");
      bus.start      = 1'b1;
      bus.vec_len    = 8'd5;
      bus.prec_level = 2'd1;
      bus.in_valid   = 1'b1;
      m_prec = 2'd1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.act_in = 8'($urandom);
      bus.wgt_in = 8'($urandom);
      m_act = bus.act_in;
      m_wgt = bus.wgt_in;
      @(negedge clk);
      check("ab.mac_en", 32'(bus.mac_en), 1);
      check("ab.cnt", 32'(bus.beat_cnt), 1);
      bus.abort    = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.abort = 1'b0;
      check_idle("ab.after");
      check("ab.act", 32'(bus.act_out), 32'(m_act));
      idle(4);
      @(negedge clk);
      bus.start      = 1'b1;
      bus.vec_len    = 8'd5;
      bus.prec_level = 2'd2;
      bus.in_valid   = 1'b1;
      bus.act_in     = 8'hA5;
      bus.wgt_in     = 8'h5A;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("rs.busy_pre", 32'(bus.busy), 1);
      check("rs.prec_pre", 32'(bus.prec_out), 2);
      rstn = 1'b0;
      #1;
      check_zero("rs.during");
      m_act  = '0;
      m_wgt  = '0;
      m_prec = '0;
      @(negedge clk);
      check_zero("rs.hold");
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rstn = 1'b1;
   endtask

   initial begin
      rstn           = 1'b0;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.vec_len    = '0;
      bus.prec_level = '0;
      bus.act_in     = '0;
      bus.wgt_in     = '0;
      bus.in_valid   = 1'b0;
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      run_op(3, 0, 1, 1'b0);
      run_op(4, 0, 2, 1'b0);
      run_op(0, 0, 1, 1'b0);
      run_op(5, 3, 1, 1'b0);
      idle(2);
      run_op(2, 1, 1, 1'b1);
      run_op(3, 2, 1, 1'b0);
      abort_then_reset();
      run_op(3, 1, 0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 0,
                1'($urandom));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
